// File: rtl/warp_scheduler.sv
// Single-issue warp scheduler: walks one warp at a time through FETCH..UPDATE,
// then picks the next warp round-robin while tracking halted and barrier-parked warps.
module warp_scheduler #(
    parameter int NUM_WARPS  = 4,
    parameter int WARP_IDX_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_WARPS-1:0]  warp_enable,
    input  logic                  fetch_done,
    input  logic                  decoded_halt,
    input  logic                  decoded_sync,
    input  logic                  decoded_mem_read_enable,
    input  logic                  decoded_mem_write_enable,
    input  logic                  lsu_busy,
    output logic [2:0]            warp_state,
    output logic [WARP_IDX_W-1:0] active_warp,
    output logic                  pc_update_en,
    output logic                  sync_release,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REQUEST = 3'd3,
        S_WAIT    = 3'd4,
        S_EXECUTE = 3'd5,
        S_UPDATE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t                  state, state_n;
    logic [WARP_IDX_W-1:0]   active, active_n;
    logic [NUM_WARPS-1:0]    alive, alive_n;
    logic [NUM_WARPS-1:0]    sync_wait, sync_wait_n;
    logic                    release_q, release_n;
    logic                    wait_first, wait_first_n;

    // First set bit of mask searching cur+1, cur+2, ... wrapping, ending at cur.
    function automatic logic [WARP_IDX_W-1:0] rr_pick(
        input logic [NUM_WARPS-1:0]  mask,
        input logic [WARP_IDX_W-1:0] cur
    );
        logic [WARP_IDX_W-1:0] pick;
        logic                  found;
        int                    idx;
        pick  = cur;
        found = 1'b0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx = (int'(cur) + i) % NUM_WARPS;
            if (!found && mask[idx]) begin
                pick  = idx[WARP_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [WARP_IDX_W-1:0] lowest_set(input logic [NUM_WARPS-1:0] mask);
        logic [WARP_IDX_W-1:0] pick;
        pick = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (mask[i]) pick = i[WARP_IDX_W-1:0];
        end
        return pick;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            active     <= '0;
            alive      <= '0;
            sync_wait  <= '0;
            release_q  <= 1'b0;
            wait_first <= 1'b0;
        end else begin
            state      <= state_n;
            active     <= active_n;
            alive      <= alive_n;
            sync_wait  <= sync_wait_n;
            release_q  <= release_n;
            wait_first <= wait_first_n;
        end
    end

    // fetch_done acts as 'valid' for the fetched instruction (FETCH holds until it is seen);
    // lsu_busy acts as inverted 'ready' from the LSU (WAIT leaves only once it reads low).
    always_comb begin
        state_n      = state;
        active_n     = active;
        alive_n      = alive;
        sync_wait_n  = sync_wait;
        release_n    = 1'b0;
        wait_first_n = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (warp_enable != '0) begin
                        alive_n     = warp_enable;
                        sync_wait_n = '0;
                        active_n    = lowest_set(warp_enable);
                        state_n     = S_FETCH;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_FETCH:   if (fetch_done) state_n = S_DECODE;
            S_DECODE:  state_n = S_REQUEST;
            S_REQUEST: begin
                if (decoded_mem_read_enable || decoded_mem_write_enable) begin
                    state_n      = S_WAIT;
                    wait_first_n = 1'b1;
                end else begin
                    state_n = S_EXECUTE;
                end
            end
            S_WAIT:    if (!wait_first && !lsu_busy) state_n = S_EXECUTE;
            S_EXECUTE: state_n = S_UPDATE;
            S_UPDATE: begin
                if (decoded_halt)      alive_n[active]     = 1'b0;
                else if (decoded_sync) sync_wait_n[active] = 1'b1;
                if (alive_n == '0) begin
                    state_n = S_DONE;
                end else begin
                    // Every live warp is parked: the barrier is complete.
                    if ((alive_n & ~sync_wait_n) == '0) begin
                        sync_wait_n = '0;
                        release_n   = 1'b1;
                    end
                    active_n = rr_pick(alive_n & ~sync_wait_n, active);
                    state_n  = S_FETCH;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign warp_state   = state;
    assign active_warp  = active;
    assign pc_update_en = (state == S_UPDATE);
    assign sync_release = release_q;
    assign done         = (state == S_DONE);

endmodule
